pkt_serializer: RTL and testbench

PKT_SERIALIZER -- requirements
Module: pkt_serializer

---
 rtl/alpaca_types_packed_pkg.sv | 24 ++
 rtl/pkt_serializer.sv | 128 ++++++++++++
 tb/tb_pkt_serializer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpaca_types_packed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alpaca_types_packed_pkg
//  Description : Shared sample and beat types for the streaming datapath.
//                cx_t is one complex sample. re sits in the low half and im
//                in the high half.
//                pkt_packed_t holds SAMP_PER_CLK samples, with lane 0 in the
//                least-significant bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package alpaca_types_packed_pkg;

    localparam int WIDTH        = 16;
    localparam int SAMP_PER_CLK = 4;

    typedef struct packed {
        logic signed [WIDTH-1:0] im;
        logic signed [WIDTH-1:0] re;
    } cx_t;

    typedef cx_t [SAMP_PER_CLK-1:0] pkt_packed_t;

endpackage : alpaca_types_packed_pkg
`default_nettype wire

// File: rtl/pkt_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_serializer
//  Description : Converts a stream of SAMP_PER_CLK-sample beats into a stream
//                of single samples, checks frame length against FFT_LEN, and
//                flags frame-length violations.
//  Ports       : clk            - sole clock, rising edge
//                rst            - asynchronous reset, active low
//                s_axis_tdata   - input beat, lane 0 in the LSBs
//                s_axis_tvalid  - input beat valid
//                s_axis_tready  - input beat accepted this cycle
//                s_axis_tlast   - beat ends a frame
//                m_axis_tdata   - output complex sample
//                m_axis_tvalid  - output sample valid
//                m_axis_tready  - downstream accepts
//                m_axis_tlast   - output sample ends a frame
//                frame_err      - one-cycle pulse on a frame-length violation
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_serializer
    import alpaca_types_packed_pkg::*;
#(
    parameter type pkt_t        = pkt_packed_t,
    parameter int  SAMP_PER_CLK = 4,
    parameter int  FFT_LEN      = 16
) (
    input  logic clk,
    input  logic rst,
    input  pkt_t s_axis_tdata,
    input  logic s_axis_tvalid,
    output logic s_axis_tready,
    input  logic s_axis_tlast,
    output cx_t  m_axis_tdata,
    output logic m_axis_tvalid,
    input  logic m_axis_tready,
    output logic m_axis_tlast,
    output logic frame_err
);

    localparam int c_IDX_W  = (SAMP_PER_CLK > 1) ? $clog2(SAMP_PER_CLK) : 1;
    localparam int c_CNT_W  = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
    localparam int c_CX_W   = $bits(cx_t);
    localparam int c_BEAT_W = $bits(pkt_t);

    localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(SAMP_PER_CLK - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT  = c_CNT_W'(FFT_LEN - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    pkt_t                r_beat;
    logic                r_beat_last;
    logic [c_IDX_W-1:0]  r_index;
    logic [c_CNT_W-1:0]  r_cnt;
    // Held low through reset and for the first edge after release, so the
    // input side never advertises ready while reset is still settling.
    logic                r_up;

    logic                w_drain;
    logic                w_last_lane;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [c_BEAT_W-1:0] w_beat_bits;

    assign w_drain     = (r_state == ST_DRAIN);
    assign w_last_lane = (r_index == c_LAST_LANE);
    assign w_beat_bits = r_beat;

    // While draining, accept the next beat only in the same cycle that the
    // last lane leaves, so consecutive beats stream with no bubble.
    assign s_axis_tready = r_up & (~w_drain | (w_last_lane & m_axis_tready));

    assign m_axis_tvalid = w_drain;
    assign m_axis_tdata  = w_beat_bits[r_index*c_CX_W +: c_CX_W];
    assign m_axis_tlast  = w_drain & w_last_lane & r_beat_last;

    assign w_in_xfer  = s_axis_tvalid & s_axis_tready;
    assign w_out_xfer = m_axis_tvalid & m_axis_tready;

    // The pulse appears with the offending sample. A frame is wrong if tlast
    // arrives early, or if the FFT_LEN-th sample arrives without tlast.
    assign frame_err = w_out_xfer & (m_axis_tlast != (r_cnt == c_LAST_CNT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_beat      <= '0;
            r_beat_last <= 1'b0;
            r_index     <= '0;
            r_cnt       <= '0;
            r_up        <= 1'b0;
        end else begin
            r_up <= 1'b1;

            if (w_in_xfer) begin
                r_beat      <= s_axis_tdata;
                r_beat_last <= s_axis_tlast;
            end

            if (w_in_xfer) begin
                r_index <= '0;
            end else if (w_out_xfer) begin
                r_index <= w_last_lane ? '0 : r_index + 1'b1;
            end

            // Resynchronise to a frame boundary on either tlast or a full
            // count. This keeps one bad frame from corrupting the next.
            if (w_out_xfer) begin
                r_cnt <= (m_axis_tlast || (r_cnt == c_LAST_CNT)) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_out_xfer && w_last_lane && !w_in_xfer) r_state <= ST_EMPTY;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule : pkt_serializer
`default_nettype wire

// File: tb/tb_pkt_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_serializer
//  Description : Self-checking bench for pkt_serializer.
//                A queue of expected samples is filled from observed input
//                transfers and drained on output transfers, and a frame-position
//                counter predicts frame_err.
//                Directed frames exercise the following cases:
//                  - normal frames
//                  - stalls on the output side
//                  - back-to-back frames
//                  - short frames
//                  - long frames
//                  - reset in the middle of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_serializer;
    import alpaca_types_packed_pkg::*;

    localparam int SPC = 4;
    localparam int LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    pkt_packed_t s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    cx_t         m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        frame_err;

    always #5 clk = ~clk;

    pkt_serializer #(
        .pkt_t        (pkt_packed_t),
        .SAMP_PER_CLK (SPC),
        .FFT_LEN      (LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_err     (frame_err)
    );

    typedef struct {
        cx_t d;
        bit  last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   frame_pos = 0;
    bit   tb_up = 1'b0;
    int   n_out = 0, n_err = 0, last_err_re = -1, last_tlast_re = -1;
    int   cyc = 0, last_out_cyc = 0, max_gap = 0;
    bit   gap_valid = 1'b0;
    bit   toggle_rdy = 1'b0;
    bit   prev_stall = 1'b0;
    cx_t  prev_data;
    logic prev_last;
    int   tag = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The input side may advertise ready only after the first edge with
    // reset released.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_up <= 1'b0;
        else      tb_up <= 1'b1;
    end

    // The downstream ready is either held high or toggled every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = toggle_rdy ? ~m_axis_tready : 1'b1;
        end
    end

    // Compare process: runs every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_err;
        cyc++;
        if (!rst) begin
            q.delete();
            frame_pos = 0;
            prev_stall = 1'b0;
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_m_tlast", m_axis_tlast, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_s_tready", s_axis_tready, 0);
        end else begin
            chk("m_tvalid", m_axis_tvalid, q.size() != 0);
            chk("s_tready", s_axis_tready,
                tb_up && (q.size() == 0 || (q.size() == 1 && m_axis_tready)));
            if (prev_stall) begin
                chk("hold_data", m_axis_tdata, prev_data);
                chk("hold_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected none", m_axis_tdata);
                end else begin
                    e = q.pop_front();
                    chk("out_data", m_axis_tdata, e.d);
                    chk("out_tlast", m_axis_tlast, e.last);
                    exp_err = e.last ? (frame_pos != LEN - 1) : (frame_pos == LEN - 1);
                    chk("frame_err", frame_err, exp_err);
                    frame_pos = (e.last || frame_pos == LEN - 1) ? 0 : frame_pos + 1;
                end
                n_out++;
                if (m_axis_tlast) last_tlast_re = int'(m_axis_tdata.re);
                if (frame_err) begin
                    n_err++;
                    last_err_re = int'(m_axis_tdata.re);
                end
                if (gap_valid && (cyc - last_out_cyc) > max_gap) max_gap = cyc - last_out_cyc;
                gap_valid = 1'b1;
                last_out_cyc = cyc;
            end else begin
                chk("frame_err_idle", frame_err, 0);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                for (int l = 0; l < SPC; l++) begin
                    e.d    = s_axis_tdata[l];
                    e.last = s_axis_tlast && (l == SPC - 1);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send_beat(input int base, input bit last);
        pkt_packed_t beat;
        bit acc;
        for (int l = 0; l < SPC; l++) begin
            beat[l].re = 16'(base + l);
            beat[l].im = 16'(tag * 256 + base + l + 16'h4000);
        end
        s_axis_tdata  = beat;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
        end
        chk("beat_accepted", acc, 1);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // last_beat < 0 sends the frame with no tlast at all.
    task automatic send_frame(input int nbeats, input int last_beat);
        tag++;
        for (int b = 0; b < nbeats; b++) send_beat(b * SPC, b == last_beat);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drained", q.size(), 0);
    endtask

    task automatic start_test(output int o0, output int e0);
        o0 = n_out;
        e0 = n_err;
        max_gap = 0;
        gap_valid = 1'b0;
        last_tlast_re = -1;
        last_err_re = -1;
    endtask

    int o0, e0;

    initial begin
        // Reset and release.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("tready_low_after_release", s_axis_tready, 0);
        @(posedge clk);
        #1;
        chk("tready_high_after_edge", s_axis_tready, 1);

        // Ramp, downstream always ready.
        start_test(o0, e0);
        send_frame(4, 3);
        idle();
        wait_drain();
        chk("t1_count", n_out - o0, 16);
        chk("t1_errs", n_err - e0, 0);
        chk("t1_tlast_re", last_tlast_re, 15);
        chk("t1_no_bubble", max_gap, 1);

        // Ramp, downstream ready toggling.
        start_test(o0, e0);
        toggle_rdy = 1'b1;
        send_frame(4, 3);
        idle();
        wait_drain();
        toggle_rdy = 1'b0;
        chk("t2_count", n_out - o0, 16);
        chk("t2_errs", n_err - e0, 0);
        chk("t2_tlast_re", last_tlast_re, 15);

        // Back-to-back frames with continuous valid.
        start_test(o0, e0);
        send_frame(4, 3);
        send_frame(4, 3);
        idle();
        wait_drain();
        chk("t3_count", n_out - o0, 32);
        chk("t3_errs", n_err - e0, 0);
        chk("t3_no_bubble", max_gap, 1);

        // Short frame (tlast on beat 3), then a good frame.
        start_test(o0, e0);
        send_frame(3, 2);
        send_frame(4, 3);
        idle();
        wait_drain();
        chk("t4_count", n_out - o0, 28);
        chk("t4_errs", n_err - e0, 1);
        chk("t4_err_re", last_err_re, 11);
        chk("t4_tlast_re", last_tlast_re, 15);

        // Long frame (no tlast), then a good frame.
        start_test(o0, e0);
        send_frame(4, -1);
        send_frame(4, 3);
        idle();
        wait_drain();
        chk("t5_count", n_out - o0, 32);
        chk("t5_errs", n_err - e0, 1);
        chk("t5_err_re", last_err_re, 15);

        // Reset after 6 samples, then a clean ramp.
        start_test(o0, e0);
        tag++;
        send_beat(0, 1'b0);
        send_beat(4, 1'b0);
        idle();
        for (int t = 0; t < 200 && (n_out - o0) < 6; t++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_six_out", n_out - o0, 6);
        rst = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_m_tlast", m_axis_tlast, 0);
        chk("t6_rst_s_tready", s_axis_tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t6_tready_low_after_release", s_axis_tready, 0);
        start_test(o0, e0);
        send_frame(4, 3);
        idle();
        wait_drain();
        chk("t6_count", n_out - o0, 16);
        chk("t6_errs", n_err - e0, 0);
        chk("t6_tlast_re", last_tlast_re, 15);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_pkt_serializer
`default_nettype wire
